// File: rtl/share_generator.sv
// Converts two unmasked operands into 2-share Boolean masked form using masks drawn from a 32-bit Galois LFSR.
// Optional macro SHARE_ZEROIZE_EN clears the share outputs after a drain-only cycle.
module share_generator #(
  parameter int          WIDTH         = 8,
  parameter int          WARMUP_CYCLES = 4,
  parameter logic [31:0] POLY          = 32'h80200003
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] secret_a,
  input  logic [WIDTH-1:0] secret_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] b0,
  output logic [WIDTH-1:0] b1,
  output logic             seeded
);

  typedef enum logic [1:0] {NOSEED, WARMUP, RUN} state_t;

  state_t           state;
  logic [7:0]       warm_cnt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_adv;
  logic [31:0]      seed_load;
  logic [WIDTH-1:0] mask_a_p0;
  logic [WIDTH-1:0] mask_b_p0;
  logic             accept;
  logic             drain;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Consume a full 2*WIDTH steps per transaction so no mask bit is ever reused.
  always_comb begin
    lfsr_adv = lfsr;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      lfsr_adv = lfsr_step(lfsr_adv);
    end
  end

  assign seed_load = (seed == 32'h0) ? 32'h1 : seed;
  assign mask_a_p0 = lfsr[WIDTH-1:0];
  assign mask_b_p0 = lfsr[2*WIDTH-1:WIDTH];
  assign in_ready  = (state == RUN) && !seed_valid && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign seeded    = (state == RUN);

  // Control: seed loading, warm-up sequencing and mask consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NOSEED;
      warm_cnt <= 8'd0;
      lfsr     <= 32'h1;
    end else if (seed_valid) begin
      state    <= WARMUP;
      warm_cnt <= 8'd0;
      lfsr     <= seed_load;
    end else begin
      case (state)
        WARMUP: begin
          lfsr <= lfsr_step(lfsr);
          if (warm_cnt == 8'(WARMUP_CYCLES - 1)) begin
            state <= RUN;
          end else begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end
        RUN: begin
          if (accept) begin
            lfsr <= lfsr_adv;
          end
        end
        default: begin
          state <= NOSEED;
        end
      endcase
    end
  end

  // Output stage p1: 1-deep buffer; secrets only ever enter through the mask XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a0        <= secret_a ^ mask_a_p0;
      a1        <= mask_a_p0;
      b0        <= secret_b ^ mask_b_p0;
      b1        <= mask_b_p0;
    end else if (drain) begin
      out_valid <= 1'b0;
`ifdef SHARE_ZEROIZE_EN
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_share_generator.sv
// Directed bench for share_generator: reset, seeding/warm-up, back-to-back masking table, stalls, reseed and async reset.
module tb_share_generator;

  localparam int          WIDTH = 8;
  localparam logic [31:0] POLY  = 32'h80200003;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             seed_valid;
  logic [31:0]      seed;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] secret_a;
  logic [WIDTH-1:0] secret_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a0, a1, b0, b1;
  logic             seeded;

  int checks = 0;
  int errors = 0;

  share_generator #(.WIDTH(WIDTH), .WARMUP_CYCLES(4), .POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .secret_a(secret_a), .secret_b(secret_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .seeded(seeded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] xa;
    logic [7:0] xb;
  } vec_t;

  vec_t        vecs [24];
  logic [31:0] mlfsr;
  logic [7:0]  ema, emb, hold_a0, hold_a1, hold_b0, hold_b1;

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ POLY;
    return n;
  endfunction

  function automatic logic [31:0] model_steps(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = model_step(r);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " seeded"}, 32'(seeded), 32'd0);
    chk({tag, " shares"}, {a0, a1, b0, b1}, 32'd0);
  endtask

  // Take the model masks for the next accept and advance the model by 2*WIDTH steps.
  task automatic take_masks();
    ema   = mlfsr[7:0];
    emb   = mlfsr[15:8];
    mlfsr = model_steps(mlfsr, 2 * WIDTH);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 20; i++) vecs[i] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[20] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[21] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[22] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[23] = '{8'h01, 8'h80, 8'h01, 8'h80};

    rst_n = 1'b0; seed_valid = 1'b0; seed = '0; in_valid = 1'b0;
    secret_a = '0; secret_b = '0; out_ready = 1'b0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No seed: requests must be ignored.
    in_valid = 1'b1; secret_a = 8'hA5; secret_b = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_zero_outputs("noseed");
    end
    in_valid = 1'b0;

    // Zero seed is replaced by 1; warm-up of four steps.
    seed_valid = 1'b1; seed = 32'h0;
    tick();
    seed_valid = 1'b0;
    chk("zero seed load", dut.lfsr, 32'h00000001);
    tick();
    chk("first step", dut.lfsr, 32'h80200003);
    chk("seeded warm1", 32'(seeded), 32'd0);
    tick();
    tick();
    chk("seeded warm3", 32'(seeded), 32'd0);
    tick();
    chk("seeded after warmup", 32'(seeded), 32'd1);
    chk("lfsr after warmup", dut.lfsr, 32'hB02C0003);
    mlfsr = model_steps(32'h1, 4);

    // Back-to-back table, one output per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; secret_a = vecs[i].sa; secret_b = vecs[i].sb;
      #1;
      chk("b2b in_ready", 32'(in_ready), 32'd1);
      take_masks();
      tick();
      chk("b2b out_valid", 32'(out_valid), 32'd1);
      chk("b2b recombine a", 32'(a0 ^ a1), 32'(vecs[i].xa));
      chk("b2b recombine b", 32'(b0 ^ b1), 32'(vecs[i].xb));
      chk("b2b masks", {a1, b1}, {ema, emb});
      if (i == 0) chk("first shares", {a0, a1, b0, b1}, 32'hA603_3C00);
    end
    hold_a0 = 8'h01 ^ ema; hold_a1 = ema; hold_b0 = 8'h80 ^ emb; hold_b1 = emb;
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(out_valid), 32'd0);
`ifdef SHARE_ZEROIZE_EN
    chk("drain zeroize", {a0, a1, b0, b1}, 32'd0);
`else
    chk("drain hold", {a0, a1, b0, b1}, {hold_a0, hold_a1, hold_b0, hold_b1});
`endif

    // Stall with a pending output, then drain+accept in one cycle.
    out_ready = 1'b0; in_valid = 1'b1; secret_a = 8'h11; secret_b = 8'h22;
    #1;
    chk("stall accept ready", 32'(in_ready), 32'd1);
    take_masks();
    tick();
    secret_a = 8'h33; secret_b = 8'h44;
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall shares", {a0, a1, b0, b1}, {8'h11 ^ ema, ema, 8'h22 ^ emb, emb});
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("drain+accept ready", 32'(in_ready), 32'd1);
    take_masks();
    tick();
    chk("drain+accept valid", 32'(out_valid), 32'd1);
    chk("drain+accept shares", {a0, a1, b0, b1}, {8'h33 ^ ema, ema, 8'h44 ^ emb, emb});
    hold_a0 = 8'h33 ^ ema; hold_a1 = ema; hold_b0 = 8'h44 ^ emb; hold_b1 = emb;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reseed while an output is pending.
    seed_valid = 1'b1; seed = 32'h12345678; in_valid = 1'b1;
    #1;
    chk("reseed in_ready", 32'(in_ready), 32'd0);
    tick();
    seed_valid = 1'b0; in_valid = 1'b0;
    chk("reseed pending valid", 32'(out_valid), 32'd1);
    chk("reseed pending shares", {a0, a1, b0, b1}, {hold_a0, hold_a1, hold_b0, hold_b1});
    out_ready = 1'b1;
    tick();
    chk("reseed drained", 32'(out_valid), 32'd0);
    chk("reseed warm in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("reseed warm3 seeded", 32'(seeded), 32'd0);
    tick();
    chk("reseed seeded", 32'(seeded), 32'd1);
    chk("reseed in_ready back", 32'(in_ready), 32'd1);
    mlfsr = model_steps(32'h12345678, 4);
    in_valid = 1'b1; secret_a = 8'h5A; secret_b = 8'hC3;
    take_masks();
    tick();
    chk("reseed shares", {a0, a1, b0, b1}, {8'h5A ^ ema, ema, 8'hC3 ^ emb, emb});

    // Async reset in the middle of traffic.
    secret_a = 8'h77; secret_b = 8'h88;
    tick();
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    chk("async reset lfsr", dut.lfsr, 32'h00000001);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero_outputs("post-reset noseed");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
